// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage types: FSM state encoding and the reset/bubble instruction.
// S_FAULT exists only when FETCH_MISALIGN_TRAP_EN is defined.
package instr_fetch_pkg;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4,
        S_FAULT = 3'd5
    } fetch_state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } fetch_state_t;
`endif

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding imem read, 3 cycles/instr with zero-wait memory; holds instr while stall.
// FETCH_MISALIGN_TRAP_EN: misaligned redirects raise a sticky fetch_fault instead of being silently aligned.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    output logic        fetch_fault
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         instr_valid_q, instr_valid_d;
    logic [31:0]  redir_tgt;
    logic         drain_needed;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fetch_fault_q, fetch_fault_d;
    logic misalign;
    assign redir_tgt = redirect_pc;
    assign misalign  = (redirect_pc[1:0] != 2'b00);
`else
    logic unused_redirect_lsbs;
    assign redir_tgt            = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

    // A response is still owed by memory if a request was just accepted or is in flight.
    assign drain_needed = (state_q == S_REQ   &&  imem_ready)
                       || (state_q == S_WAIT  && !imem_rvalid)
                       || (state_q == S_DRAIN && !imem_rvalid);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        fetch_fault_d = fetch_fault_q;
`endif
        if (redirect_valid) begin
            pc_d          = redir_tgt;
            instr_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fetch_fault_d = misalign;
            if (drain_needed)  state_d = S_DRAIN;
            else if (misalign) state_d = S_FAULT;
            else               state_d = S_REQ;
`else
            state_d = drain_needed ? S_DRAIN : S_REQ;
`endif
        end else begin
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (imem_ready) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + 32'd4;
                        state_d       = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        instr_valid_d = 1'b0;
                        state_d       = S_REQ;
                    end
                end
                S_DRAIN: begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (imem_rvalid) state_d = fetch_fault_q ? S_FAULT : S_REQ;
`else
                    if (imem_rvalid) state_d = S_REQ;
`endif
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= INSTR_NOP;
            instr_pc_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fetch_fault_q <= 1'b0;
        else     fetch_fault_q <= fetch_fault_d;
    end
    assign fetch_fault = fetch_fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

    assign imem_req       = (state_q == S_REQ);
    assign imem_addr      = pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign instr_pc_plus4 = instr_pc_q + 32'd4;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then randomized memory/redirect/stall traffic against a
// transaction-level model (expected next fetch address, expected delivered PC, hold stability).
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic        fetch_fault;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4),
        .fetch_fault    (fetch_fault)
    );

    int checks = 0;
    int errors = 0;

    // memory model state
    logic        ready_rand;
    int          lat_min, lat_max;
    logic        force_vld;
    logic [31:0] force_dat;
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    // reference model state
    logic [31:0] exp_next, exp_pc, out_addr, prev_instr, prev_pc;
    logic        out_vld, out_killed, exp_rise, prev_valid, prev_stall, prev_redirect, exp_fault;

    // samples taken on the falling edge
    logic        s_req, s_valid, s_fault;
    logic [31:0] s_addr, s_instr, s_pc, s_p4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] align(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
        return t;
`else
        return {t[31:2], 2'b00};
`endif
    endfunction

    // One clock cycle: drive memory response and control inputs, sample, check, advance model.
    task automatic cyc(input logic rdr, input logic [31:0] tgt, input logic stl);
        logic        exp_v, new_rise;
        logic [31:0] e_pc;
        imem_rvalid = mem_busy && (mem_cnt == 0);
        imem_rdata  = force_vld ? force_dat : memf(mem_addr);
        if (mem_busy && mem_cnt > 0) mem_cnt--;
        imem_ready     = (!mem_busy || imem_rvalid) && (ready_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        redirect_valid = rdr;
        redirect_pc    = tgt;
        stall          = stl;
        @(negedge clk);
        s_req = imem_req;  s_addr = imem_addr;  s_valid = instr_valid;  s_instr = instr;
        s_pc  = instr_pc;  s_p4   = instr_pc_plus4;  s_fault = fetch_fault;
        if (rst) begin
            chk("rst_req", s_req, 1'b0);
            chk("rst_valid", s_valid, 1'b0);
            chk("rst_instr", s_instr, INSTR_NOP);
            chk("rst_instr_pc", s_pc, RST_PC);
            chk("rst_plus4", s_p4, RST_PC + 32'd4);
            chk("rst_addr", s_addr, RST_PC);
            chk("rst_fault", s_fault, 1'b0);
            if (imem_rvalid) out_vld = 1'b0;
            out_killed = 1'b1;
            exp_next = RST_PC; exp_rise = 1'b0; prev_valid = 1'b0; exp_fault = 1'b0;
        end else begin
            exp_v = exp_rise || (prev_valid && prev_stall && !prev_redirect);
            e_pc  = exp_rise ? exp_pc : prev_pc;
            chk("instr_valid", s_valid, exp_v);
            if (exp_rise) begin
                chk("instr", s_instr, memf(exp_pc));
                chk("instr_pc", s_pc, exp_pc);
            end else if (exp_v) begin
                chk("hold_instr", s_instr, prev_instr);
                chk("hold_pc", s_pc, prev_pc);
            end
            if (exp_v) chk("pc_plus4", s_p4, e_pc + 32'd4);
            if (s_req) chk("imem_addr", s_addr, exp_next);
            chk("fetch_fault", s_fault, exp_fault);
            new_rise = 1'b0;
            if (imem_rvalid && out_vld) begin
                if (!out_killed && !rdr) begin
                    new_rise = 1'b1;
                    exp_pc   = out_addr;
                    exp_next = out_addr + 32'd4;
                end
                out_vld = 1'b0;
            end
            if (s_req && imem_ready) begin
                out_vld = 1'b1; out_addr = s_addr; out_killed = rdr;
            end
            if (rdr) begin
                exp_next   = align(tgt);
                out_killed = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
                exp_fault  = (tgt[1:0] != 2'b00);
`endif
            end
            prev_valid = s_valid; prev_stall = stl; prev_redirect = rdr;
            prev_instr = s_instr; prev_pc = s_pc; exp_rise = new_rise;
        end
        if (imem_rvalid) mem_busy = 1'b0;
        if (imem_req && imem_ready) begin
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_cnt  = $urandom_range(lat_min - 1, lat_max - 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 32'h0, 1'b1);
            if (s_valid) break;
        end
        chk("wait_valid_timeout", s_valid, 1'b1);
    endtask

    initial begin
        logic        rdr;
        logic [31:0] tgt;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b1;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        ready_rand = 1'b0; lat_min = 1; lat_max = 1; force_vld = 1'b0; force_dat = '0;
        mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0;
        exp_next = RST_PC; exp_pc = RST_PC; out_addr = '0; prev_instr = '0; prev_pc = '0;
        out_vld = 1'b0; out_killed = 1'b0; exp_rise = 1'b0; prev_valid = 1'b0;
        prev_stall = 1'b0; prev_redirect = 1'b0; exp_fault = 1'b0;
        @(posedge clk); #1;
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        rst = 1'b0;

        // first fetch from RESET_PC with zero-wait memory
        cyc(1'b0, 32'h0, 1'b1);
        chk("idle_no_req", s_req, 1'b0);
        cyc(1'b0, 32'h0, 1'b1);
        chk("first_req", s_req, 1'b1);
        chk("first_addr", s_addr, 32'h100);
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("first_valid", s_valid, 1'b1);
        chk("first_instr", s_instr, 32'h0050_0093);
        chk("first_pc", s_pc, 32'h100);
        chk("first_plus4", s_p4, 32'h104);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 32'h0, 1'b1);
            chk("stall_req", s_req, 1'b0);
            chk("stall_instr", s_instr, 32'h0050_0093);
            chk("stall_pc", s_pc, 32'h100);
        end
        cyc(1'b0, 32'h0, 1'b0);

        // redirect in the same cycle the request for 0x104 is accepted
        force_vld = 1'b1; force_dat = 32'hDEAD_BEEF;
        cyc(1'b1, 32'h200, 1'b0);
        chk("acc_req", s_req, 1'b1);
        chk("acc_addr", s_addr, 32'h104);
        cyc(1'b0, 32'h0, 1'b1);
        chk("drain_valid", s_valid, 1'b0);
        force_vld = 1'b0;
        cyc(1'b0, 32'h0, 1'b1);
        chk("redir_req", s_req, 1'b1);
        chk("redir_addr", s_addr, 32'h200);
        chk("redir_valid", s_valid, 1'b0);
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("t200_valid", s_valid, 1'b1);
        chk("t200_pc", s_pc, 32'h200);

        // redirect from HOLD with stall low: held instruction discarded
        cyc(1'b1, 32'h300, 1'b0);
        cyc(1'b0, 32'h0, 1'b1);
        chk("hold_redir_valid", s_valid, 1'b0);
        chk("hold_redir_req", s_req, 1'b1);
        chk("hold_redir_addr", s_addr, 32'h300);

        // PC wrap at the top of the address space
        wait_valid();
        cyc(1'b1, 32'hFFFF_FFFC, 1'b0);
        wait_valid();
        chk("wrap_pc", s_pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", s_p4, 32'h0);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1);
        chk("wrap_req", s_req, 1'b1);
        chk("wrap_addr", s_addr, 32'h0);

        // misaligned redirect
        wait_valid();
        cyc(1'b1, 32'h202, 1'b0);
        cyc(1'b0, 32'h0, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_fault", s_fault, 1'b1);
        chk("mis_req", s_req, 1'b0);
`else
        chk("mis_fault", s_fault, 1'b0);
        chk("mis_req", s_req, 1'b1);
        chk("mis_addr", s_addr, 32'h200);
`endif
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 32'h0, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
            chk("fault_sticky", s_fault, 1'b1);
            chk("fault_no_req", s_req, 1'b0);
`endif
        end
        cyc(1'b1, 32'h204, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("clr_fault", s_fault, 1'b0);
        chk("clr_req", s_req, 1'b1);
        chk("clr_addr", s_addr, 32'h204);

        // reset while a 3-cycle read is in flight; the stale response must be ignored
        wait_valid();
        cyc(1'b0, 32'h0, 1'b0);
        lat_min = 3; lat_max = 3;
        cyc(1'b0, 32'h0, 1'b1);
        chk("pre_rst_req", s_req, 1'b1);
        rst = 1'b1;
        cyc(1'b0, 32'h0, 1'b1);
        rst = 1'b0;
        wait_valid();
        chk("post_rst_pc", s_pc, RST_PC);
        chk("post_rst_instr", s_instr, 32'h0050_0093);

        // randomized traffic
        ready_rand = 1'b1; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 800; i++) begin
            rdr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 + {28'h0, 2'($urandom_range(0, 3)), 2'b00};
            else                           tgt = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
`ifndef FETCH_MISALIGN_TRAP_EN
            tgt[1:0] = 2'($urandom_range(0, 3));
`endif
            cyc(rdr, tgt, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
